// File: rtl/micro_sequencer.sv
// Next-microaddress sequencer: combinational UADDR_OUT (zero latency), hardware return stack.
// Backpressure: a pending MR/MW without MEM_RDY holds the address and drops MIR_ENA_OUT.
module micro_sequencer #(
  parameter int AW = 10,
  parameter int STK_DEPTH = 4,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [6:0]    TYPE_IN,
  input  logic [AW-1:0] DADD_IN,
  input  logic          MR_IN,
  input  logic          MW_IN,
  input  logic [3:0]    FLAGS_IN,
  input  logic          IRQ_IN,
  input  logic [AW-1:0] DISP_IN,
  input  logic          MEM_RDY,
  output logic [AW-1:0] UADDR_OUT,
  output logic          MIR_ENA_OUT,
  output logic          STALL_OUT,
  output logic          HALTED_OUT,
  output logic          STK_ERR_OUT
);

  localparam int SPW = $clog2(STK_DEPTH + 1);
  localparam int IW  = $clog2(STK_DEPTH);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STK_DEPTH);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam logic [2:0] OP_NEXT  = 3'd0;
  localparam logic [2:0] OP_JUMP  = 3'd1;
  localparam logic [2:0] OP_CJUMP = 3'd2;
  localparam logic [2:0] OP_CALL  = 3'd3;
  localparam logic [2:0] OP_RET   = 3'd4;
  localparam logic [2:0] OP_DISP  = 3'd5;
  localparam logic [2:0] OP_CCALL = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  logic [1:0]     state;
  logic [AW-1:0]  upc;
  logic [SPW-1:0] sp;
  logic [AW-1:0]  stk [STK_DEPTH];

  logic [2:0]    op;
  logic          sel;
  logic          cond;
  logic          running;
  logic          stall;
  logic          exec;
  logic          do_call;
  logic          push;
  logic          pop;
  logic          err_set;
  logic [AW-1:0] upc_inc;
  logic [AW-1:0] next;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] pop_idx;
  logic [SPW-1:0] sp_dec;

  assign op       = TYPE_IN[6:4];
  assign upc_inc  = upc + AW'(1);
  assign sp_dec   = sp - SPW'(1);
  assign push_idx = sp[IW-1:0];
  assign pop_idx  = sp_dec[IW-1:0];

  always_comb begin
    sel = 1'b0;
    case (TYPE_IN[2:0])
      3'd0:    sel = 1'b1;
      3'd1:    sel = FLAGS_IN[0];
      3'd2:    sel = FLAGS_IN[1];
      3'd3:    sel = FLAGS_IN[2];
      3'd4:    sel = FLAGS_IN[3];
      3'd5:    sel = IRQ_IN;
      default: sel = 1'b0;
    endcase
    cond = TYPE_IN[3] ^ sel;
  end

  assign running = (state == ST_RUN) || (state == ST_WAIT);
  assign stall   = running && (MR_IN || MW_IN) && !MEM_RDY;
  assign exec    = running && !stall;
  assign do_call = (op == OP_CALL) || ((op == OP_CCALL) && cond);

  always_comb begin
    next    = upc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (do_call) begin
      // Overflow still takes the jump; only the return address is lost.
      next = DADD_IN;
      if (sp == SP_FULL) err_set = 1'b1;
      else               push    = 1'b1;
    end else begin
      case (op)
        OP_JUMP:  next = DADD_IN;
        OP_CJUMP: if (cond) next = DADD_IN;
        OP_RET: begin
          if (sp == '0) begin
            err_set = 1'b1;
          end else begin
            next = stk[pop_idx];
            pop  = 1'b1;
          end
        end
        OP_DISP:  next = DISP_IN;
        OP_HALT:  next = upc;
        default:  next = upc_inc;
      endcase
    end
  end

  always_comb begin
    UADDR_OUT   = upc;
    MIR_ENA_OUT = 1'b0;
    if (state == ST_BOOT) begin
      UADDR_OUT   = RESET_VEC;
      MIR_ENA_OUT = 1'b1;
    end else if (exec && (op != OP_HALT)) begin
      UADDR_OUT   = next;
      MIR_ENA_OUT = 1'b1;
    end
  end

  assign STALL_OUT  = stall;
  assign HALTED_OUT = (state == ST_HALT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_BOOT;
      upc         <= RESET_VEC;
      sp          <= '0;
      STK_ERR_OUT <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_RUN;
          upc   <= RESET_VEC;
        end
        ST_RUN, ST_WAIT: begin
          if (stall) begin
            state <= ST_WAIT;
          end else begin
            if (op == OP_HALT) begin
              state <= ST_HALT;
            end else begin
              state <= ST_RUN;
              upc   <= next;
            end
            if (push)    sp <= sp + SPW'(1);
            if (pop)     sp <= sp_dec;
            if (err_set) STK_ERR_OUT <= 1'b1;
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  // Stack storage needs no reset: SP=0 already marks every entry invalid.
  always_ff @(posedge CLK) begin
    if (exec && push) stk[push_idx] <= upc_inc;
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer; the bench plays the MIR by driving TYPE/DADD per step.
module tb_micro_sequencer;
  logic       CLK = 1'b0;
  logic       RST_N;
  logic [6:0] TYPE_IN;
  logic [9:0] DADD_IN;
  logic       MR_IN;
  logic       MW_IN;
  logic [3:0] FLAGS_IN;
  logic       IRQ_IN;
  logic [9:0] DISP_IN;
  logic       MEM_RDY;
  logic [9:0] UADDR_OUT;
  logic       MIR_ENA_OUT;
  logic       STALL_OUT;
  logic       HALTED_OUT;
  logic       STK_ERR_OUT;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] T_NEXT  = 7'h00;
  localparam logic [6:0] T_JUMP  = 7'h10;
  localparam logic [6:0] T_CJZ   = 7'h21;
  localparam logic [6:0] T_CJNZ  = 7'h29;
  localparam logic [6:0] T_CALL  = 7'h30;
  localparam logic [6:0] T_RET   = 7'h40;
  localparam logic [6:0] T_DISP  = 7'h50;
  localparam logic [6:0] T_CCIRQ = 7'h65;
  localparam logic [6:0] T_HALT  = 7'h70;

  micro_sequencer #(.AW(10), .STK_DEPTH(4), .RESET_VEC(10'h000)) dut (
    .CLK(CLK), .RST_N(RST_N), .TYPE_IN(TYPE_IN), .DADD_IN(DADD_IN),
    .MR_IN(MR_IN), .MW_IN(MW_IN), .FLAGS_IN(FLAGS_IN), .IRQ_IN(IRQ_IN),
    .DISP_IN(DISP_IN), .MEM_RDY(MEM_RDY), .UADDR_OUT(UADDR_OUT),
    .MIR_ENA_OUT(MIR_ENA_OUT), .STALL_OUT(STALL_OUT), .HALTED_OUT(HALTED_OUT),
    .STK_ERR_OUT(STK_ERR_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [9:0] ea, input logic ee,
                     input logic es, input logic eh, input logic er);
    checks++;
    assert (UADDR_OUT === ea) else begin
      errors++; $error("FAIL %s uaddr got %h expected %h", tag, UADDR_OUT, ea);
    end
    checks++;
    assert (MIR_ENA_OUT === ee) else begin
      errors++; $error("FAIL %s mir_ena got %b expected %b", tag, MIR_ENA_OUT, ee);
    end
    checks++;
    assert (STALL_OUT === es) else begin
      errors++; $error("FAIL %s stall got %b expected %b", tag, STALL_OUT, es);
    end
    checks++;
    assert (HALTED_OUT === eh) else begin
      errors++; $error("FAIL %s halted got %b expected %b", tag, HALTED_OUT, eh);
    end
    checks++;
    assert (STK_ERR_OUT === er) else begin
      errors++; $error("FAIL %s stk_err got %b expected %b", tag, STK_ERR_OUT, er);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  task automatic mir(input logic [6:0] t, input logic [9:0] d);
    TYPE_IN = t;
    DADD_IN = d;
    #1;
  endtask

  initial begin
    RST_N = 1'b0; TYPE_IN = T_NEXT; DADD_IN = '0; MR_IN = 1'b0; MW_IN = 1'b0;
    FLAGS_IN = '0; IRQ_IN = 1'b0; DISP_IN = '0; MEM_RDY = 1'b0;
    #3 chk("reset", 10'h000, 1, 0, 0, 0);
    @(posedge CLK);
    tick;
    RST_N = 1'b1;
    #1 chk("boot", 10'h000, 1, 0, 0, 0);

    // NEXT chain from the reset vector
    tick; chk("seq1", 10'h001, 1, 0, 0, 0);
    tick; chk("seq2", 10'h002, 1, 0, 0, 0);
    tick; chk("seq3", 10'h003, 1, 0, 0, 0);
    tick;
    mir(T_JUMP, 10'h010); chk("jump", 10'h010, 1, 0, 0, 0);
    tick;

    // Conditional jump on Z, plain and inverted
    FLAGS_IN = 4'b0001; mir(T_CJZ, 10'h2A0); chk("cj_z1", 10'h2A0, 1, 0, 0, 0);
    FLAGS_IN = 4'b0000; #1 chk("cj_z0", 10'h011, 1, 0, 0, 0);
    TYPE_IN = T_CJNZ;   #1 chk("cjn_z0", 10'h2A0, 1, 0, 0, 0);
    FLAGS_IN = 4'b0001; #1 chk("cjn_z1", 10'h011, 1, 0, 0, 0);
    FLAGS_IN = 4'b0000;
    mir(T_JUMP, 10'h020); chk("jump2", 10'h020, 1, 0, 0, 0);
    tick;

    // Call / return, then overflow with five nested calls
    mir(T_CALL, 10'h100); chk("call", 10'h100, 1, 0, 0, 0); tick;
    mir(T_RET, 10'h000);  chk("ret", 10'h021, 1, 0, 0, 0); tick;
    mir(T_CALL, 10'h200); chk("nest1", 10'h200, 1, 0, 0, 0); tick;
    mir(T_CALL, 10'h210); chk("nest2", 10'h210, 1, 0, 0, 0); tick;
    mir(T_CALL, 10'h220); chk("nest3", 10'h220, 1, 0, 0, 0); tick;
    mir(T_CALL, 10'h230); chk("nest4", 10'h230, 1, 0, 0, 0); tick;
    mir(T_CALL, 10'h240); chk("nest5", 10'h240, 1, 0, 0, 0); tick;
    mir(T_RET, 10'h000);  chk("pop4", 10'h221, 1, 0, 0, 1); tick;
    chk("pop3", 10'h211, 1, 0, 0, 1); tick;
    chk("pop2", 10'h201, 1, 0, 0, 1); tick;
    chk("pop1", 10'h022, 1, 0, 0, 1); tick;
    chk("ret_empty", 10'h023, 1, 0, 0, 1); tick;

    // Memory stall: three cycles held, jump executes on the MEM_RDY cycle
    MR_IN = 1'b1; MEM_RDY = 1'b0;
    mir(T_JUMP, 10'h3FF); chk("stall1", 10'h023, 0, 1, 0, 1);
    tick; chk("stall2", 10'h023, 0, 1, 0, 1);
    tick; chk("stall3", 10'h023, 0, 1, 0, 1);
    tick; MEM_RDY = 1'b1;
    #1 chk("stall_go", 10'h3FF, 1, 0, 0, 1);
    tick;
    MR_IN = 1'b0; MEM_RDY = 1'b0;

    // Wrap, dispatch, halt
    mir(T_NEXT, 10'h000); chk("wrap", 10'h000, 1, 0, 0, 1); tick;
    DISP_IN = 10'h155;
    mir(T_DISP, 10'h000); chk("dispatch", 10'h155, 1, 0, 0, 1); tick;
    mir(T_HALT, 10'h000); chk("halt_op", 10'h155, 0, 0, 0, 1); tick;
    chk("halted", 10'h155, 0, 0, 1, 1);
    mir(T_NEXT, 10'h000); tick;
    chk("halt_hold", 10'h155, 0, 0, 1, 1);
    #1 RST_N = 1'b0;
    #1 chk("halt_rst", 10'h000, 1, 0, 0, 0);
    #1 RST_N = 1'b1;
    tick;

    // Conditional call on IRQ, building stack depth 2
    mir(T_CCIRQ, 10'h080); chk("ccall_n", 10'h001, 1, 0, 0, 0);
    IRQ_IN = 1'b1; #1 chk("ccall_y", 10'h080, 1, 0, 0, 0);
    tick; IRQ_IN = 1'b0;
    mir(T_CALL, 10'h300); chk("call_d2", 10'h300, 1, 0, 0, 0); tick;

    // Async reset in WAIT with two stack entries
    MW_IN = 1'b1; MEM_RDY = 1'b0;
    mir(T_RET, 10'h000); chk("w_stall", 10'h300, 0, 1, 0, 0);
    tick; #1 chk("w_wait", 10'h300, 0, 1, 0, 0);
    #1 RST_N = 1'b0;
    #1 chk("async_rst", 10'h000, 1, 0, 0, 0);
    #1 RST_N = 1'b1; MW_IN = 1'b0;
    #1 chk("boot3", 10'h000, 1, 0, 0, 0);
    tick;
    chk("stk_cleared", 10'h001, 1, 0, 0, 0);
    tick;
    chk("underflow_err", 10'h002, 1, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
